// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and instruction-word output bus of instr_encoder
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_fmt;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  err_fmt;
  logic                  err_range;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_fmt, err_range
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_fmt, err_range
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-to-word encoder with output FIFO and sequential word address
// Optional immediate range checking is enabled by defining RANGE_CHECK_EN.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  instr_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]           mem_q [FIFO_DEPTH];
  logic [31:0]           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  err_fmt_q, err_fmt_d;
  logic                  err_range_q, err_range_d;

  logic [31:0]      enc_word;
  logic             fmt_ok;
  logic             range_ok;
  logic             accept;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rd_next;

  always_comb begin
    enc_word = 32'h0;
    fmt_ok   = 1'b1;
    range_ok = 1'b1;
    case (bus.in_fmt)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd1: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      3'd2: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_imm[4:0], bus.in_opcode};
      3'd3: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      3'd4: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      3'd5: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                        bus.in_rd, bus.in_opcode};
      default: fmt_ok = 1'b0;
    endcase
`ifdef RANGE_CHECK_EN
    // The immediate must survive truncation unchanged; B/J offsets must also be halfword aligned.
    case (bus.in_fmt)
      3'd1, 3'd2: range_ok = (bus.in_imm[31:11] == {21{bus.in_imm[11]}});
      3'd3:       range_ok = (bus.in_imm[31:12] == {20{bus.in_imm[12]}}) && !bus.in_imm[0];
      3'd4:       range_ok = (bus.in_imm[11:0] == 12'h0);
      3'd5:       range_ok = (bus.in_imm[31:20] == {12{bus.in_imm[20]}}) && !bus.in_imm[0];
      default:    range_ok = 1'b1;
    endcase
`endif
  end

  assign accept  = bus.in_valid && in_ready_q && !flush;
  assign push    = accept && fmt_ok && range_ok;
  assign pop     = (count_q != '0) && bus.out_ready && !flush;
  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_fmt_d   = 1'b0;
    err_range_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_addr_d = BASE;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = enc_word;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_next;
        out_addr_d = out_addr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Head register tracks what will sit at the front next cycle; it holds when the queue drains.
      if (pop) begin
        if (count_q > CNT_W'(1)) begin
          out_instr_d = mem_q[rd_next];
        end else if (push) begin
          out_instr_d = enc_word;
        end
      end else if ((count_q == '0) && push) begin
        out_instr_d = enc_word;
      end
      err_fmt_d = accept && !fmt_ok;
`ifdef RANGE_CHECK_EN
      err_range_d = accept && fmt_ok && !range_ok;
`endif
    end
    in_ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE;
      err_fmt_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_fmt_q   <= err_fmt_d;
      err_range_q <= err_range_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err_fmt   = err_fmt_q;
  assign bus.err_range = err_range_q;
endmodule
